// File: rtl/pinmux_bbm_ctrl.sv
// Output pin multiplexer with break-before-make reselection: a reselected pin has
// its output enable held low for GUARD_CYCLES+1 cycles while the source changes.
module pinmux_bbm_ctrl #(
  parameter int PIN_NUM      = 70,
  parameter int SRC_NUM      = 4,
  parameter int GUARD_CYCLES = 4,
  parameter int SEL_W        = $clog2(SRC_NUM+1),
  parameter int PIN_W        = $clog2(PIN_NUM)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [PIN_W-1:0]           cfg_pin_i,
  input  logic [SEL_W-1:0]           cfg_sel_i,
  output logic                       cfg_err_o,
  output logic                       busy_o,
  input  logic [PIN_NUM*SRC_NUM-1:0] src_out_i,
  input  logic [PIN_NUM*SRC_NUM-1:0] src_oe_i,
  output logic [PIN_NUM-1:0]         pin_out_o,
  output logic [PIN_NUM-1:0]         pin_oe_o,
  output logic [PIN_NUM*SEL_W-1:0]   sel_o
);

  localparam int CNT_W = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES+1);

  if (GUARD_CYCLES < 1) begin : g_bad_guard
    $error("GUARD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BREAK, MAKE} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [PIN_W-1:0]              pin_q, pin_d;
  logic [SEL_W-1:0]              nsel_q, nsel_d;
  logic [PIN_NUM-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [PIN_NUM-1:0]            guard_q, guard_d;
  logic [PIN_NUM-1:0]            out_q, out_d;
  logic [PIN_NUM-1:0]            oe_q, oe_d;
  logic                          err_q, err_d;

  // Source mux: selection s picks packed bit p*SRC_NUM+s-1; 0 drives nothing.
  always_comb begin
    out_d = '0;
    oe_d  = '0;
    for (int p = 0; p < PIN_NUM; p++) begin
      for (int s = 0; s < SRC_NUM; s++) begin
        if (sel_q[p] == SEL_W'(s+1)) begin
          out_d[p] = src_out_i[p*SRC_NUM+s];
          oe_d[p]  = src_oe_i[p*SRC_NUM+s];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    nsel_d  = nsel_q;
    sel_d   = sel_q;
    guard_d = guard_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          if (int'(cfg_pin_i) >= PIN_NUM || int'(cfg_sel_i) > SRC_NUM) begin
            err_d = 1'b1;
          end else if (cfg_sel_i != sel_q[cfg_pin_i]) begin
            pin_d              = cfg_pin_i;
            nsel_d             = cfg_sel_i;
            guard_d[cfg_pin_i] = 1'b1;
            cnt_d              = CNT_W'(GUARD_CYCLES-1);
            state_d            = BREAK;
          end
        end
      end
      BREAK: begin
        if (cnt_q == '0) begin
          sel_d[pin_q] = nsel_q;
          state_d      = MAKE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MAKE: begin
        // out_q/oe_q reload from the new source on this edge, so the guard can drop
        guard_d[pin_q] = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pin_q   <= '0;
      nsel_q  <= '0;
      sel_q   <= '0;
      guard_q <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      nsel_q  <= nsel_d;
      sel_q   <= sel_d;
      guard_q <= guard_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = ~cfg_ready_o;
  assign cfg_err_o   = err_q;
  assign pin_out_o   = out_q;
  assign pin_oe_o    = oe_q & ~guard_q;
  assign sel_o       = sel_q;

endmodule

// File: tb/tb_pinmux_bbm_ctrl.sv
// Bench for pinmux_bbm_ctrl: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based reference model of the reselection timeline.
module tb_pinmux_bbm_ctrl;
  localparam int PN = 10, SN = 4, G = 3;
  localparam int SW = $clog2(SN+1), PW = $clog2(PN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [PW-1:0] cfg_pin = '0;
  logic [SW-1:0] cfg_sel = '0;
  logic          cfg_ready, cfg_err, busy;
  logic [PN*SN-1:0] src_out = '0, src_oe = '1;
  logic [PN-1:0]    pin_out, pin_oe;
  logic [PN*SW-1:0] sel_o;

  always #5 clk = ~clk;

  pinmux_bbm_ctrl #(.PIN_NUM(PN), .SRC_NUM(SN), .GUARD_CYCLES(G)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_pin_i(cfg_pin), .cfg_sel_i(cfg_sel), .cfg_err_o(cfg_err), .busy_o(busy),
    .src_out_i(src_out), .src_oe_i(src_oe), .pin_out_o(pin_out), .pin_oe_o(pin_oe),
    .sel_o(sel_o));

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  // reference model: current selection per pin plus one pending request with its accept time
  int m_sel[PN];
  bit m_pend, m_acc, e_err, rnd_oe;
  int m_pin, m_nsel, m_ta;
  logic [PN-1:0] e_out, e_oe;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [PN-1:0]    gmask;
    logic [PN*SW-1:0] esel;
    gmask = '0;
    if (m_pend) gmask[m_pin] = 1'b1;
    for (int p = 0; p < PN; p++) esel[p*SW +: SW] = SW'(m_sel[p]);
    chk("pin_out", 64'(pin_out), 64'(e_out));
    chk("pin_oe", 64'(pin_oe), 64'(e_oe & ~gmask));
    chk("sel_o", 64'(sel_o), 64'(esel));
    chk("ready", 64'(cfg_ready), 64'(!m_pend));
    chk("busy", 64'(busy), 64'(m_pend));
    chk("err", 64'(cfg_err), 64'(e_err));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    m_acc = 1'b0;
    e_err = 1'b0;
    if (!rst_n) begin
      foreach (m_sel[p]) m_sel[p] = 0;
      m_pend = 1'b0;
      e_out = '0;
      e_oe = '0;
    end else begin
      for (int p = 0; p < PN; p++) begin
        e_out[p] = (m_sel[p] == 0) ? 1'b0 : src_out[p*SN + m_sel[p] - 1];
        e_oe[p]  = (m_sel[p] == 0) ? 1'b0 : src_oe[p*SN + m_sel[p] - 1];
      end
      if (m_pend) begin
        if (cyc == m_ta + G) m_sel[m_pin] = m_nsel;
        else if (cyc == m_ta + G + 1) m_pend = 1'b0;
      end else if (cfg_valid) begin
        m_acc = 1'b1;
        if (int'(cfg_pin) >= PN || int'(cfg_sel) > SN) e_err = 1'b1;
        else if (int'(cfg_sel) != m_sel[cfg_pin]) begin
          m_pend = 1'b1; m_pin = cfg_pin; m_nsel = cfg_sel; m_ta = cyc;
        end
      end
    end
    #1;
    check_all();
    src_out = {$urandom, $urandom};
    src_out[6*SN] = cyc[0];
    if (rnd_oe) src_oe = {$urandom, $urandom};
  endtask

  task automatic req(input int pin, input int sel, output int t_acc);
    int n;
    cfg_valid = 1'b1; cfg_pin = PW'(pin); cfg_sel = SW'(sel);
    n = 0;
    t_acc = -1;
    while (t_acc < 0 && n < 50) begin
      step();
      n++;
      if (m_acc) t_acc = cyc;
    end
    cfg_valid = 1'b0;
    if (t_acc < 0) chk("req_timeout", 64'(n), 64'(0));
  endtask

  initial begin
    int t, n;
    int acc[3];
    rnd_oe = 1'b0;
    foreach (m_sel[p]) m_sel[p] = 0;
    m_pend = 1'b0;
    // reset with every source enable high
    repeat (3) step();
    chk("rst_oe", 64'(pin_oe), 64'(0));
    rst_n = 1'b1;
    step();

    // basic select: ready must be low for G+1 cycles
    req(6, 1, t);
    repeat (5) step();
    req(5, 2, t);
    n = 0;
    while (!cfg_ready && n < 20) begin n++; step(); end
    chk("ready_low_cycles", 64'(n), 64'(G+1));
    chk("sel5_basic", 64'(sel_o[5*SW +: SW]), 64'(2));
    step();

    // reselect with both enables high: pad enable low exactly G+1 cycles
    req(5, 1, t);
    n = 0;
    while (!pin_oe[5] && n < 20) begin n++; step(); end
    chk("bbm_low_cycles", 64'(n), 64'(G+1));
    repeat (3) step();

    // errors then no-op
    req(PN, 1, t);
    chk("err_pin", 64'(cfg_err), 64'(1));
    req(0, SN+1, t);
    chk("err_sel", 64'(cfg_err), 64'(1));
    step();
    chk("err_clear", 64'(cfg_err), 64'(0));
    req(5, 1, t);
    chk("noop_ready", 64'(cfg_ready), 64'(1));
    chk("noop_err", 64'(cfg_err), 64'(0));
    step();

    // reset two cycles into the guard window
    req(3, 4, t);
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_sel", 64'(sel_o), 64'(0));
    chk("rst_mid_ready", 64'(cfg_ready), 64'(1));
    rst_n = 1'b1;
    step();

    // back-to-back stream with valid held high
    cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit hs;
      cfg_pin = PW'(k == 1 ? 2 : 1);
      cfg_sel = SW'(k + 2);
      acc[k] = -1;
      n = 0;
      while (acc[k] < 0 && n < 50) begin
        hs = cfg_ready;
        step();
        n++;
        if (hs) acc[k] = cyc;
      end
    end
    cfg_valid = 1'b0;
    chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'(G+2));
    chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'(G+2));
    repeat (G+3) step();
    chk("b2b_sel1", 64'(sel_o[1*SW +: SW]), 64'(4));
    chk("b2b_sel2", 64'(sel_o[2*SW +: SW]), 64'(3));

    // random traffic, including out-of-range requests and occasional resets
    rnd_oe = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cfg_valid = ($urandom_range(0, 2) != 0);
      cfg_pin   = PW'($urandom_range(0, 11));
      cfg_sel   = SW'($urandom_range(0, 5));
      rst_n     = ($urandom_range(0, 150) != 0);
      step();
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
